// File: rtl/key_reader.sv
// Debounced active-low key input: per-key synchroniser, debounce counter and
// hold/auto-repeat FSM producing clean level plus press/release/repeat pulses.

module key_lane #(
  parameter int DB_CNT     = 5,
  parameter int HOLD_CNT   = 20,
  parameter int REPEAT_CNT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);
  localparam int DBW  = $clog2(DB_CNT + 1);
  localparam int HMAX = (HOLD_CNT > REPEAT_CNT) ? HOLD_CNT : REPEAT_CNT;
  localparam int HW   = $clog2(((HMAX > 1) ? HMAX : 1) + 1);

  typedef enum logic [1:0] {IDLE, WAIT_HOLD, REPEAT} hold_t;

  logic           sync1, sync2, pressed;
  logic [DBW-1:0] db_cnt;
  logic           flip, rise, fall;
  hold_t          state, state_nx;
  logic [HW-1:0]  hcnt, hcnt_nx;
  logic           rep_nx;

  assign pressed = ~sync2;
  assign flip    = (pressed != key_state) && (db_cnt == DBW'(DB_CNT - 1));
  assign rise    = flip & ~key_state;
  assign fall    = flip &  key_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      db_cnt      <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync1       <= key_raw;
      sync2       <= sync1;
      key_press   <= rise;
      key_release <= fall;
      if (pressed == key_state) db_cnt <= '0;
      else if (flip) begin
        db_cnt    <= '0;
        key_state <= ~key_state;
      end else db_cnt <= db_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      hcnt       <= '0;
      key_repeat <= 1'b0;
    end else begin
      state      <= state_nx;
      hcnt       <= hcnt_nx;
      key_repeat <= rep_nx;
    end
  end

  // A falling edge overrides everything so no repeat lands on the release cycle.
  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt;
    rep_nx   = 1'b0;
    if (HOLD_CNT == 0) begin
      state_nx = IDLE;
      hcnt_nx  = '0;
    end else if (fall) begin
      state_nx = IDLE;
      hcnt_nx  = '0;
    end else begin
      case (state)
        IDLE: if (rise) begin
          state_nx = WAIT_HOLD;
          hcnt_nx  = HW'(1);
        end
        WAIT_HOLD: if (hcnt == HW'(HOLD_CNT)) begin
          rep_nx   = 1'b1;
          state_nx = REPEAT;
          hcnt_nx  = HW'(1);
        end else hcnt_nx = hcnt + 1'b1;
        REPEAT: if (hcnt == HW'(REPEAT_CNT)) begin
          rep_nx  = 1'b1;
          hcnt_nx = HW'(1);
        end else hcnt_nx = hcnt + 1'b1;
        default: state_nx = IDLE;
      endcase
    end
  end
endmodule

module key_reader #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int NKEY        = 4,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLD_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NKEY-1:0] key_in,
  output logic [NKEY-1:0] key_state,
  output logic [NKEY-1:0] key_press,
  output logic [NKEY-1:0] key_release,
  output logic [NKEY-1:0] key_repeat
);
  localparam int DB_CNT     = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int HOLD_CNT   = CLK_FREQ / 1000 * HOLD_MS;
  localparam int REPEAT_CNT = CLK_FREQ / 1000 * REPEAT_MS;

  key_lane #(
    .DB_CNT(DB_CNT), .HOLD_CNT(HOLD_CNT), .REPEAT_CNT(REPEAT_CNT)
  ) u_lane [NKEY-1:0] (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_raw    (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat)
  );
endmodule

// File: tb/tb_key_reader.sv
// Directed stimulus with a cycle-stamped event scoreboard checked every cycle.

module tb_key_reader;
  localparam int NK = 4, LAT = 7, HOLD = 20, REP = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_in, key_state, key_press, key_release, key_repeat;

  key_reader #(
    .CLK_FREQ(1000), .NKEY(NK), .DEBOUNCE_MS(5), .HOLD_MS(20), .REPEAT_MS(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_repeat (key_repeat)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int key; int kind;} ev_t;  // kind 0 press, 1 release, 2 repeat
  ev_t sb[$];

  int cyc = 0, checks = 0, errors = 0;
  bit rst_edge = 1'b1;
  int pcyc [NK];
  logic [NK-1:0] exp_state = '0, ep, er, et;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !rst_n;
  end

  task automatic chk(input string tag, input logic [NK-1:0] got, input logic [NK-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      ep = '0; er = '0; et = '0;
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].cyc == cyc) begin
          case (sb[i].kind)
            0:       ep[sb[i].key] = 1'b1;
            1:       er[sb[i].key] = 1'b1;
            default: et[sb[i].key] = 1'b1;
          endcase
          sb.delete(i);
        end
      if (rst_edge) begin
        exp_state = '0; ep = '0; er = '0; et = '0;
      end else exp_state = (exp_state | ep) & ~er;
      chk("key_state",   key_state,   exp_state);
      chk("key_press",   key_press,   ep);
      chk("key_release", key_release, er);
      chk("key_repeat",  key_repeat,  et);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void push(input int c, input int k, input int kind);
    ev_t e;
    e.cyc = c; e.key = k; e.kind = kind;
    sb.push_back(e);
  endfunction

  // Press: schedule the press pulse and a long train of repeats; release trims them.
  task automatic down(input logic [NK-1:0] m);
    key_in = key_in & ~m;
    for (int k = 0; k < NK; k++)
      if (m[k]) begin
        pcyc[k] = cyc + LAT;
        push(pcyc[k], k, 0);
        for (int j = 0; j < 20; j++) push(pcyc[k] + HOLD + j * REP, k, 2);
      end
  endtask

  task automatic up(input logic [NK-1:0] m);
    int r;
    key_in = key_in | m;
    r = cyc + LAT;
    for (int k = 0; k < NK; k++)
      if (m[k]) begin
        for (int i = sb.size() - 1; i >= 0; i--)
          if (sb[i].key == k && sb[i].kind == 2 && sb[i].cyc >= r) sb.delete(i);
        push(r, k, 1);
      end
  endtask

  initial begin
    rst_n  = 1'b0;
    key_in = '1;
    step(3);
    rst_n = 1'b1;
    step(50);

    // clean press / release on key 0
    down(4'b0001); step(15);
    up(4'b0001);   step(12);

    // bouncing press on key 1, then a lone 4-cycle glitch
    key_in[1] = 1'b0; step(4);
    key_in[1] = 1'b1; step(1);
    key_in[1] = 1'b0; step(3);
    key_in[1] = 1'b1; step(1);
    down(4'b0010); step(12);
    up(4'b0010);   step(12);
    key_in[1] = 1'b0; step(4);
    key_in[1] = 1'b1; step(12);

    // auto-repeat on key 2
    down(4'b0100); step(60);
    up(4'b0100);   step(12);

    // simultaneous keys 0 and 3, release 0 first
    down(4'b1001); step(10);
    up(4'b0001);   step(12);
    up(4'b1000);   step(12);

    // reset while key 2 is in REPEAT, key kept held through reset
    down(4'b0100); step(LAT + HOLD + 2);
    sb.delete();
    rst_n = 1'b0;  step(1);
    rst_n = 1'b1;
    down(4'b0100); step(10);
    up(4'b0100);   step(12);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
